// File: rtl/debug_dump_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_tx_if
//  Description : Bundle of the debug dump transmitter's bus signals:
//                dump request/status, register-file and data-memory read
//                ports, and the UART TX byte handshake.
//                master modport : the dump transmitter (drives o_*)
//                slave  modport : its environment (drives i_*)
//  Ports (signals):
//    i_start, i_pc              dump request and PC snapshot
//    o_reg_addr, i_reg_data     register-file read port (1-cycle latency)
//    o_mem_addr, i_mem_data     data-memory read port (1-cycle latency)
//    o_tx_start, o_tx_data,
//    i_tx_done                  UART TX byte handshake
//    o_busy, o_done             dump status
//  Revision    : 1.0  initial release
// ============================================================================
interface debug_dump_tx_if #(
    parameter int NB_DATA  = 32,
    parameter int BYTE     = 8,
    parameter int RB_ADDR  = 5,
    parameter int MEM_ADDR = 5
);
    logic                i_start;
    logic [NB_DATA-1:0]  i_pc;
    logic [RB_ADDR-1:0]  o_reg_addr;
    logic [NB_DATA-1:0]  i_reg_data;
    logic [MEM_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0]  i_mem_data;
    logic                i_tx_done;
    logic                o_tx_start;
    logic [BYTE-1:0]     o_tx_data;
    logic                o_busy;
    logic                o_done;

    modport master (
        input  i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
        output o_reg_addr, o_mem_addr, o_tx_start, o_tx_data, o_busy, o_done
    );

    modport slave (
        output i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
        input  o_reg_addr, o_mem_addr, o_tx_start, o_tx_data, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_tx
//  Description : Transmit half of the debug UART link. On a dump request it
//                snapshots the PC, then reads every register and every
//                data-memory word, sending each word as 4 bytes MSB first
//                over the UART TX byte handshake.
//                Bytes per dump = 4 * (1 + N_REGS + N_MEM).
//  Ports:
//    i_clock  system clock, rising edge
//    i_reset  asynchronous active-low reset
//    io_dbg   debug_dump_tx_if.master: request/status, register and memory
//             read ports, UART TX handshake
//  Revision    : 1.0  initial release
// ============================================================================
module debug_dump_tx #(
    parameter int NB_DATA  = 32,
    parameter int BYTE     = 8,
    parameter int RB_ADDR  = 5,
    parameter int N_REGS   = 32,
    parameter int MEM_ADDR = 5,
    parameter int N_MEM    = 32
) (
    input  wire logic         i_clock,
    input  wire logic         i_reset,
    debug_dump_tx_if.master   io_dbg
);

    localparam int c_IDX_W = (RB_ADDR > MEM_ADDR) ? RB_ADDR : MEM_ADDR;
    localparam logic [c_IDX_W-1:0] c_REG_LAST = c_IDX_W'(N_REGS - 1);
    localparam logic [c_IDX_W-1:0] c_MEM_LAST = c_IDX_W'(N_MEM - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [1:0]         c_LAST_BYTE = 2'(NB_DATA / BYTE - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_PC  = 3'd1,
        S_SET_ADDR = 3'd2,
        S_WAIT_RD  = 3'd3,
        S_SEND     = 3'd4,
        S_WAIT_TX  = 3'd5,
        S_NEXT     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_PC  = 2'd0,
        PH_REG = 2'd1,
        PH_MEM = 2'd2
    } phase_t;

    state_t                r_state,    w_state_next;
    phase_t                r_phase,    w_phase_next;
    logic [NB_DATA-1:0]    r_word,     w_word_next;
    logic [1:0]            r_byte_idx, w_byte_next;
    logic [c_IDX_W-1:0]    r_idx,      w_idx_next;
    logic [RB_ADDR-1:0]    r_reg_addr, w_reg_addr_next;
    logic [MEM_ADDR-1:0]   r_mem_addr, w_mem_addr_next;

    logic [c_IDX_W-1:0]    w_idx_inc;
    logic [NB_DATA-1:0]    w_shift;

    assign w_idx_inc = r_idx + c_IDX_ONE;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_phase    <= PH_PC;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_idx      <= '0;
            r_reg_addr <= '0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_phase    <= w_phase_next;
            r_word     <= w_word_next;
            r_byte_idx <= w_byte_next;
            r_idx      <= w_idx_next;
            r_reg_addr <= w_reg_addr_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    // The read address is loaded on the transition out of NEXT, so it is
    // already stable on the bus for the whole SET_ADDR cycle. With a 1-cycle
    // read latency the word then appears during WAIT_RD and is latched at
    // the end of it.
    always_comb begin
        w_state_next    = r_state;
        w_phase_next    = r_phase;
        w_word_next     = r_word;
        w_byte_next     = r_byte_idx;
        w_idx_next      = r_idx;
        w_reg_addr_next = r_reg_addr;
        w_mem_addr_next = r_mem_addr;

        case (r_state)
            S_IDLE: begin
                if (io_dbg.i_start) begin
                    w_word_next  = io_dbg.i_pc;
                    w_phase_next = PH_PC;
                    w_idx_next   = '0;
                    w_state_next = S_LOAD_PC;
                end
            end
            S_LOAD_PC: begin
                w_byte_next  = '0;
                w_state_next = S_SEND;
            end
            S_SET_ADDR: begin
                w_state_next = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                w_word_next  = (r_phase == PH_REG) ? io_dbg.i_reg_data
                                                   : io_dbg.i_mem_data;
                w_byte_next  = '0;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                w_state_next = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (io_dbg.i_tx_done) begin
                    if (r_byte_idx != c_LAST_BYTE) begin
                        w_byte_next  = r_byte_idx + 2'd1;
                        w_state_next = S_SEND;
                    end else begin
                        w_state_next = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                w_state_next = S_SET_ADDR;
                case (r_phase)
                    PH_PC: begin
                        w_phase_next    = PH_REG;
                        w_idx_next      = '0;
                        w_reg_addr_next = '0;
                    end
                    PH_REG: begin
                        if (r_idx < c_REG_LAST) begin
                            w_idx_next      = w_idx_inc;
                            w_reg_addr_next = w_idx_inc[RB_ADDR-1:0];
                        end else begin
                            w_phase_next    = PH_MEM;
                            w_idx_next      = '0;
                            w_mem_addr_next = '0;
                        end
                    end
                    default: begin
                        if (r_idx < c_MEM_LAST) begin
                            w_idx_next      = w_idx_inc;
                            w_mem_addr_next = w_idx_inc[MEM_ADDR-1:0];
                        end else begin
                            w_state_next = S_DONE;
                        end
                    end
                endcase
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Byte 0 is the most significant byte of the word.
    assign w_shift = r_word << (BYTE * r_byte_idx);

    assign io_dbg.o_tx_start = (r_state == S_SEND);
    assign io_dbg.o_tx_data  = w_shift[NB_DATA-1 -: BYTE];
    assign io_dbg.o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign io_dbg.o_done     = (r_state == S_DONE);
    assign io_dbg.o_reg_addr = r_reg_addr;
    assign io_dbg.o_mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_dump_tx
//  Description : Self-checking bench for debug_dump_tx. Instance 0 uses the
//                default sizes (260-byte dump), instance 1 uses N_REGS=4,
//                N_MEM=2 (28-byte dump). Expected bytes are queued when a
//                dump is requested and popped as the DUT launches bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debug_dump_tx;

    localparam int ACK_DLY = 8;
    localparam int HOLD    = 500;

    logic clk;
    logic rst_n;

    logic        r_start   [2];
    logic [31:0] r_pc      [2];
    logic        r_stray   [2];
    logic        r_ack     [2];
    logic [31:0] r_reg_rd  [2];
    logic [31:0] r_mem_rd  [2];

    logic        w_tx_start [2];
    logic [7:0]  w_tx_data  [2];
    logic        w_busy     [2];
    logic        w_done     [2];
    logic [4:0]  w_reg_addr [2];
    logic [4:0]  w_mem_addr [2];

    int errors = 0;
    int checks = 0;

    logic [7:0] q_exp[$];

    int          cyc = 0;
    int          n_start  [2];
    int          n_done   [2];
    int          last_ack [2];
    int          ack_cnt  [2];
    int          hold_at  [2];
    logic        pending  [2];
    logic [7:0]  held     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NR = (g == 0) ? 32 : 4;
        localparam int NM = (g == 0) ? 32 : 2;

        debug_dump_tx_if u_if ();

        assign u_if.i_start    = r_start[g];
        assign u_if.i_pc       = r_pc[g];
        assign u_if.i_reg_data = r_reg_rd[g];
        assign u_if.i_mem_data = r_mem_rd[g];
        assign u_if.i_tx_done  = r_ack[g] | r_stray[g];

        assign w_tx_start[g] = u_if.o_tx_start;
        assign w_tx_data[g]  = u_if.o_tx_data;
        assign w_busy[g]     = u_if.o_busy;
        assign w_done[g]     = u_if.o_done;
        assign w_reg_addr[g] = u_if.o_reg_addr;
        assign w_mem_addr[g] = u_if.o_mem_addr;

        debug_dump_tx #(.N_REGS(NR), .N_MEM(NM)) u_dut (
            .i_clock (clk),
            .i_reset (rst_n),
            .io_dbg  (u_if)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memories: data for address k appears only in the
    // cycle after k was presented.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            r_reg_rd[d] <= 32'hA000_0000 + 32'(w_reg_addr[d]);
            r_mem_rd[d] <= 32'h5A00_0000 + 32'(w_mem_addr[d]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Monitor, scoreboard and UART ack model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pending[d] = 1'b0;
                r_ack[d]   = 1'b0;
                ack_cnt[d] = 0;
            end else begin
                if (r_ack[d]) begin
                    r_ack[d]    = 1'b0;
                    pending[d]  = 1'b0;
                    last_ack[d] = cyc;
                end
                if (w_tx_start[d]) begin
                    check("no_double_start", {31'd0, pending[d]}, 32'd0);
                    n_start[d]++;
                    if (q_exp.size() == 0) begin
                        check("unexpected_byte", 32'(q_exp.size()), 32'd1);
                    end else begin
                        e = q_exp.pop_front();
                        check("tx_byte", {24'd0, w_tx_data[d]}, {24'd0, e});
                    end
                    pending[d] = 1'b1;
                    held[d]    = w_tx_data[d];
                    ack_cnt[d] = (n_start[d] == hold_at[d]) ? ACK_DLY + HOLD : ACK_DLY;
                end else if (pending[d]) begin
                    check("tx_data_stable", {24'd0, w_tx_data[d]}, {24'd0, held[d]});
                    if (ack_cnt[d] > 0) begin
                        ack_cnt[d]--;
                        if (ack_cnt[d] == 0) r_ack[d] = 1'b1;
                    end
                end
                if (w_done[d]) begin
                    n_done[d]++;
                    // DONE follows the NEXT bookkeeping cycle after the last ack.
                    check("done_latency", 32'(cyc - last_ack[d]), 32'd1);
                    check("done_queue_empty", 32'(q_exp.size()), 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) q_exp.push_back(w[31-8*b -: 8]);
    endtask

    task automatic push_dump(input logic [31:0] pc, input int nr, input int nm);
        push_word(pc);
        for (int k = 0; k < nr; k++) push_word(32'hA000_0000 + 32'(k));
        for (int k = 0; k < nm; k++) push_word(32'h5A00_0000 + 32'(k));
    endtask

    task automatic pulse_start(input int d, input logic [31:0] pc);
        step();
        r_pc[d]    = pc;
        r_start[d] = 1'b1;
        step();
        r_start[d] = 1'b0;
        check("busy_after_start", {31'd0, w_busy[d]}, 32'd1);
    endtask

    task automatic wait_starts(input int d, input int target, input int budget);
        int n = 0;
        while (n_start[d] < target && n < budget) begin
            step();
            n++;
        end
        if (n_start[d] < target) begin
            checks++;
            errors++;
            $error("FAIL wait_starts: observed=%0d expected=%0d", n_start[d], target);
        end
    endtask

    task automatic wait_done(input int d, input int base, input int budget);
        int n = 0;
        while (n_done[d] == base && n < budget) begin
            step();
            n++;
        end
        if (n_done[d] == base) begin
            checks++;
            errors++;
            $error("FAIL wait_done: observed=timeout expected=o_done within %0d cycles", budget);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_tx_start"}, {31'd0, w_tx_start[d]}, 32'd0);
        check({tag, "_tx_data"},  {24'd0, w_tx_data[d]},  32'd0);
        check({tag, "_busy"},     {31'd0, w_busy[d]},     32'd0);
        check({tag, "_done"},     {31'd0, w_done[d]},     32'd0);
        check({tag, "_reg_addr"}, {27'd0, w_reg_addr[d]}, 32'd0);
        check({tag, "_mem_addr"}, {27'd0, w_mem_addr[d]}, 32'd0);
    endtask

    initial begin
        int bs;
        int bd;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            r_start[d] = 1'b0;
            r_pc[d]    = '0;
            r_stray[d] = 1'b0;
            r_ack[d]   = 1'b0;
            n_start[d] = 0;
            n_done[d]  = 0;
            last_ack[d] = 0;
            ack_cnt[d] = 0;
            hold_at[d] = -1;
            pending[d] = 1'b0;
            held[d]    = '0;
        end

        // Reset state of both instances
        step();
        step();
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        rst_n = 1'b1;
        step();

        // Stray tx_done while idle must do nothing
        r_stray[0] = 1'b1;
        step();
        r_stray[0] = 1'b0;
        step();
        check("idle_stray_busy", {31'd0, w_busy[0]}, 32'd0);
        check("idle_stray_start_cnt", 32'(n_start[0]), 32'd0);

        // Full dump with back-pressure on byte 7 and a stray start at byte 100
        bs = n_start[0];
        bd = n_done[0];
        hold_at[0] = bs + 7;
        push_dump(32'h0000_0040, 32, 32);
        pulse_start(0, 32'h0000_0040);
        wait_starts(0, bs + 100, 5000);
        r_pc[0]    = 32'hFFFF_FFFF;
        r_start[0] = 1'b1;
        step();
        r_start[0] = 1'b0;
        wait_done(0, bd, 10000);
        step();
        step();
        check("dump1_bytes", 32'(n_start[0] - bs), 32'd260);
        check("dump1_dones", 32'(n_done[0] - bd), 32'd1);
        check("dump1_busy_after", {31'd0, w_busy[0]}, 32'd0);
        hold_at[0] = -1;

        // Asynchronous reset in the middle of byte 50
        bs = n_start[0];
        bd = n_done[0];
        push_dump(32'h1234_5678, 32, 32);
        pulse_start(0, 32'h1234_5678);
        wait_starts(0, bs + 50, 2000);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, "async_rst");
        step();
        step();
        #2;
        rst_n = 1'b1;
        q_exp.delete();
        for (int i = 0; i < 20; i++) step();
        check("abort_no_done", 32'(n_done[0] - bd), 32'd0);
        check("abort_idle", {31'd0, w_busy[0]}, 32'd0);

        // Fresh dump after reset starts from the PC bytes
        bs = n_start[0];
        bd = n_done[0];
        push_dump(32'hCAFE_F00D, 32, 32);
        pulse_start(0, 32'hCAFE_F00D);
        wait_done(0, bd, 10000);
        step();
        check("dump2_bytes", 32'(n_start[0] - bs), 32'd260);
        check("dump2_dones", 32'(n_done[0] - bd), 32'd1);

        // Small variant: 4 registers, 2 memory words
        bs = n_start[1];
        bd = n_done[1];
        push_dump(32'h0000_0100, 4, 2);
        pulse_start(1, 32'h0000_0100);
        wait_done(1, bd, 2000);
        step();
        step();
        check("small_bytes", 32'(n_start[1] - bs), 32'd28);
        check("small_dones", 32'(n_done[1] - bd), 32'd1);
        check("small_busy_after", {31'd0, w_busy[1]}, 32'd0);
        check("small_queue_empty", 32'(q_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
